gray_to_color_serializer: RTL
=============================

GRAY_TO_COLOR_SERIALIZER -- requirements
Module: gray_to_color_serializer

Interface
REQ-001 Parameter SIZE, default 10, SHALL set the number of 8-bit grayscale pixels per input row; legal range 2..64.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004 Port gray_in, input, [7:0] x SIZE unpacked array, SHALL carry one grayscale row; element 0 is the first pixel emitted.
REQ-005 Port in_valid, input, 1 bit, SHALL indicate that gray_in and mode_in are valid.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a row this cycle.
REQ-007 Port mode_in, input, 1 bit, SHALL select color mapping: 0 = replicate, 1 = heat map.
REQ-008 Ports R_out, G_out, B_out, outputs, 8 bits each, SHALL carry the current output pixel.
REQ-009 Port out_valid, output, 1 bit, SHALL indicate that R_out/G_out/B_out/out_last are valid.
REQ-010 Port out_ready, input, 1 bit, SHALL indicate that the downstream consumer takes the pixel this cycle.
REQ-011 Port out_last, output, 1 bit, SHALL be high with the pixel at index SIZE-1.

Function
REQ-012 The block SHALL implement two states: IDLE and SEND.
REQ-013 In IDLE, in_ready SHALL be 1; in SEND, in_ready SHALL be 0 (no row overlap).
REQ-014 A row SHALL be accepted when in_valid && in_ready; on that edge: gray_in is copied into an internal SIZE x 8 row buffer, mode_in is latched, the index counter is set to 0, and the state moves to SEND.
REQ-015 Latency: pixel 0 SHALL appear with out_valid = 1 on the first cycle after the accepting edge.
REQ-016 An output handshake SHALL occur when out_valid && out_ready; on that edge, the index increments and the next pixel is registered onto the outputs.
REQ-017 While out_valid && !out_ready, R_out, G_out, B_out and out_last SHALL hold stable.
REQ-018 On the handshake of index SIZE-1 (out_last = 1), the state SHALL return to IDLE and out_valid SHALL drop to 0 on the next cycle; the index SHALL not wrap past SIZE-1.
REQ-019 Mode 0 SHALL output R = G = B = g, where g is the buffered pixel at the current index.
REQ-020 Mode 1 SHALL output R = (g >= 128) ? 255 : 2*g; G = (g >= 128) ? 2*(g-128) : 0; B = (g < 64) ? 255 - 4*g : 0; all results 8-bit, with no overflow possible by construction.
REQ-021 Peak throughput SHALL be one pixel per cycle while out_ready = 1; one row therefore occupies SIZE+1 cycles, including one accept cycle.
REQ-022 Changes on gray_in or mode_in during SEND SHALL have no effect on the row in flight.
REQ-023 in_valid asserted during SEND SHALL be ignored; the upstream source holds the row until in_ready = 1.

Reset
REQ-024 When rst = 1 at a clock edge, the block SHALL go to IDLE with index = 0 and latched mode = 0, and drive out_valid = 0, out_last = 0, R_out = G_out = B_out = 0, and in_ready = 1 from the next cycle.
REQ-025 A reset during SEND SHALL abort the row immediately; no further pixels from that row are emitted.
REQ-026 rst SHALL take priority over a simultaneous input or output handshake.
REQ-027 Row buffer contents need no reset value.

Verification
REQ-028 SIZE = 10, mode 0, row = 0,10,...,90, out_ready held at 1 -> 10 pixels on consecutive cycles starting one cycle after accept; R = G = B = 10*i; out_last only on value 90; in_ready = 1 again on the cycle after the last handshake.
REQ-029 Mode 1, pixels 0, 63, 64, 127, 128, 255 -> (R,G,B) = (0,0,255), (126,0,3), (128,0,0), (254,0,0), (255,0,0), (255,254,0).
REQ-030 Back-pressure: out_ready toggles 1,0,0,1,... -> outputs hold stable while stalled; no pixel is dropped or duplicated; order is preserved.
REQ-031 in_valid held high during SEND with a different row and mode -> the in-flight row is unaffected; the second row is accepted only in IDLE, and its pixel 0 follows the previous out_last by at least 2 cycles.
REQ-032 rst asserted at pixel index 4 -> the next cycle shows out_valid = 0, in_ready = 1, and all outputs 0; a new row then streams from index 0 correctly.

Source files
------------

// File: rtl/gray_to_color_serializer.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_color_serializer
// Brief    : Buffers one grayscale row and streams it out as RGB pixels,
//            either replicated gray or a heat-map colouring, with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module gray_to_color_serializer #(
    parameter int SIZE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gray_in [SIZE],
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode_in,
    output logic [7:0] R_out,
    output logic [7:0] G_out,
    output logic [7:0] B_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int                 c_IDX_W    = $clog2(SIZE);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SIZE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [7:0]         r_buf [SIZE];
    logic               r_mode;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_accept;
    logic               w_advance;
    logic [c_IDX_W-1:0] w_next_idx;
    logic [23:0]        w_first_rgb;
    logic [23:0]        w_next_rgb;

    // Heat map: blue fades out over 0..63, red ramps over 0..127, green over 128..255.
    function automatic logic [23:0] f_map(input logic [7:0] g, input logic mode);
        logic [7:0] r_c;
        logic [7:0] g_c;
        logic [7:0] b_c;
        if (!mode) begin
            r_c = g;
            g_c = g;
            b_c = g;
        end else begin
            r_c = g[7] ? 8'hFF : {g[6:0], 1'b0};
            g_c = g[7] ? {g[6:0], 1'b0} : 8'h00;
            b_c = (g[7:6] == 2'b00) ? (8'hFF - {g[5:0], 2'b00}) : 8'h00;
        end
        return {r_c, g_c, b_c};
    endfunction

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_advance   = out_valid && out_ready;
    assign w_next_idx  = r_idx + c_IDX_W'(1);
    assign w_first_rgb = f_map(gray_in[0], mode_in);
    assign w_next_rgb  = f_map(r_buf[w_next_idx], r_mode);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= gray_in;
        end
    end

    // Pixel 0 is mapped straight from the input so it is valid the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_mode    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            R_out     <= 8'h00;
            G_out     <= 8'h00;
            B_out     <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state               <= ST_SEND;
                        r_mode                <= mode_in;
                        r_idx                 <= '0;
                        {R_out, G_out, B_out} <= w_first_rgb;
                        out_valid             <= 1'b1;
                        out_last              <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_advance) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state   <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            r_idx                 <= w_next_idx;
                            {R_out, G_out, B_out} <= w_next_rgb;
                            out_last              <= (w_next_idx == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
